// File: rtl/i2s_tdm_receiver.sv
// I2S / left-justified / TDM audio receiver: oversampled serial capture, frame-lock FSM, AXI-Stream FIFO.
// Optional saturating error counter output err_count is built in when I2S_RX_ERRCNT_EN is defined.
module i2s_tdm_receiver #(
  parameter int AUDIO_WIDTH = 24,
  parameter int SLOT_WIDTH  = 32,
  parameter int NUM_SLOTS   = 2,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                            clk_125,
  input  logic                            rst_n,
  input  logic                            en,
  input  logic [1:0]                      fmt,
  input  logic                            clr_status,
  input  logic                            bclk,
  input  logic                            lrclk,
  input  logic                            sdata,
  output logic [AUDIO_WIDTH-1:0]          m_axis_tdata,
  output logic [$clog2(NUM_SLOTS)-1:0]    m_axis_tuser,
  output logic                            m_axis_tlast,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            locked,
  output logic                            overflow,
  output logic                            frame_err
`ifdef I2S_RX_ERRCNT_EN
  ,
  output logic [15:0]                     err_count
`endif
);

  localparam int UW = $clog2(NUM_SLOTS);
  localparam int CW = $clog2(SLOT_WIDTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] CNT_FULL  = CW'(SLOT_WIDTH);
  localparam logic [CW-1:0] CNT_WORD  = CW'(AUDIO_WIDTH);
  localparam logic [UW-1:0] SLOT_LAST = UW'(NUM_SLOTS - 1);

  typedef enum logic [1:0] {FMT_I2S = 2'b00, FMT_LJ = 2'b01, FMT_TDM = 2'b10, FMT_RSVD = 2'b11} fmt_e;
  typedef enum logic {ST_HUNT = 1'b0, ST_RUN = 1'b1} state_e;

  typedef struct packed {
    logic [AUDIO_WIDTH-1:0] data;
    logic [UW-1:0]          user;
    logic                   last;
  } beat_t;

  fmt_e fmt_sel;
  assign fmt_sel = fmt_e'(fmt);

  // ---------------------------------------------------------------- input capture
  logic [1:0] bclk_sync_q, lrclk_sync_q, sdata_sync_q;
  logic       bclk_prev_q;
  logic       bclk_rise, lr_s, sd_s;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_125 or negedge rst_n) begin
    if (!rst_n) begin
      bclk_sync_q  <= '0;
      lrclk_sync_q <= '0;
      sdata_sync_q <= '0;
      bclk_prev_q  <= 1'b0;
    end else begin
      bclk_sync_q  <= {bclk_sync_q[0], bclk};
      lrclk_sync_q <= {lrclk_sync_q[0], lrclk};
      sdata_sync_q <= {sdata_sync_q[0], sdata};
      bclk_prev_q  <= bclk_sync_q[1];
    end
  end

  assign bclk_rise = bclk_sync_q[1] & ~bclk_prev_q;
  assign lr_s      = lrclk_sync_q[1];
  assign sd_s      = sdata_sync_q[1];

  // ---------------------------------------------------------------- slot framing / deserialiser
  state_e                 state_q, state_d;
  logic                   lr_prev_q, lr_prev_d;
  logic                   pend_q, pend_d;
  logic [UW-1:0]          pend_slot_q, pend_slot_d;
  logic                   active_q, active_d;
  logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [UW-1:0]          slot_q, slot_d;
  logic [AUDIO_WIDTH-1:0] word_q, word_d;
  logic                   push_pend_q, push_pend_d;

  logic          lr_edge, take, adv, start_now, sync_err, short_err;
  logic [UW-1:0] start_slot, lr_slot;

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    lr_prev_d   = lr_prev_q;
    pend_d      = pend_q;
    pend_slot_d = pend_slot_q;
    active_d    = active_q;
    bit_cnt_d   = bit_cnt_q;
    slot_d      = slot_q;
    word_d      = word_q;
    start_now   = 1'b0;
    start_slot  = '0;
    adv         = 1'b0;
    take        = 1'b0;
    sync_err    = 1'b0;
    short_err   = 1'b0;
    lr_edge     = lr_s ^ lr_prev_q;
    lr_slot     = (fmt_sel == FMT_LJ) ? UW'(~lr_s) : UW'(lr_s);

    if (bclk_rise) begin
      lr_prev_d = lr_s;
      // LJ opens the slot on the edge itself; I2S/TDM open it one bclk later.
      if (fmt_sel == FMT_LJ) begin
        start_now  = lr_edge;
        start_slot = lr_slot;
      end else begin
        start_now  = pend_q;
        start_slot = pend_slot_q;
      end
      pend_d      = lr_edge & ((fmt_sel == FMT_TDM) ? lr_s : (fmt_sel != FMT_LJ));
      pend_slot_d = (fmt_sel == FMT_TDM) ? '0 : lr_slot;
      adv = (fmt_sel == FMT_TDM) && active_q && !start_now &&
            (bit_cnt_q == CNT_FULL) && (slot_q != SLOT_LAST);

      if (start_now && active_q && state_q == ST_RUN) begin
        // A frame sync is legal only when it reopens slot 0 exactly after a complete frame.
        if (fmt_sel == FMT_TDM)
          sync_err = !(((slot_q == SLOT_LAST) && (bit_cnt_q == CNT_FULL)) ||
                       ((slot_q == '0) && (bit_cnt_q == '0)));
        else
          short_err = (bit_cnt_q < CNT_WORD);
      end

      if (start_now || adv) begin
        active_d  = 1'b1;
        bit_cnt_d = CW'(1);
        slot_d    = start_now ? start_slot : slot_q + UW'(1);
        word_d    = '0;
        word_d[0] = sd_s;
        take      = 1'b1;
      end else if (active_q && bit_cnt_q != CNT_FULL) begin
        bit_cnt_d = bit_cnt_q + CW'(1);
        if (bit_cnt_q < CNT_WORD) begin
          word_d    = word_q << 1;
          word_d[0] = sd_s;
          take      = 1'b1;
        end
      end
    end

    push_pend_d = take && (bit_cnt_d == CNT_WORD);
    if (!en) begin
      active_d    = 1'b0;
      pend_d      = 1'b0;
      push_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk_125 or negedge rst_n) begin
    if (!rst_n) begin
      lr_prev_q   <= 1'b0;
      pend_q      <= 1'b0;
      pend_slot_q <= '0;
      active_q    <= 1'b0;
      bit_cnt_q   <= '0;
      slot_q      <= '0;
      word_q      <= '0;
      push_pend_q <= 1'b0;
    end else begin
      lr_prev_q   <= lr_prev_d;
      pend_q      <= pend_d;
      pend_slot_q <= pend_slot_d;
      active_q    <= active_d;
      bit_cnt_q   <= bit_cnt_d;
      slot_q      <= slot_d;
      word_q      <= word_d;
      push_pend_q <= push_pend_d;
    end
  end

  // ---------------------------------------------------------------- lock FSM
  always_ff @(posedge clk_125 or negedge rst_n) begin
    if (!rst_n) state_q <= ST_HUNT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HUNT: if (en && start_now && start_slot == '0) state_d = ST_RUN;
      ST_RUN:  if (!en || sync_err)                     state_d = ST_HUNT;
      default:                                          state_d = ST_HUNT;
    endcase
  end

  always_comb begin
    locked = (state_q == ST_RUN);
  end

  // ---------------------------------------------------------------- output FIFO
  beat_t         mem [FIFO_DEPTH];
  beat_t         wr_beat, rd_beat;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q, count_d;
  logic          push_req, push_ok, pop, full, empty, ovf_evt, ferr_evt;

  assign full     = (count_q == (PW+1)'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign pop      = !empty && m_axis_tready;
  assign push_req = push_pend_q && (state_q == ST_RUN);
  // A full FIFO still accepts a word in the cycle its head is being popped.
  assign push_ok  = push_req && (!full || pop);
  assign ovf_evt  = push_req && full && !pop;
  assign ferr_evt = short_err || sync_err;
  assign wr_beat  = '{data: word_q, user: slot_q, last: (slot_q == SLOT_LAST)};

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: the storage array carries no reset; empty masks its contents from the outputs.
  always_ff @(posedge clk_125) begin
    if (push_ok) mem[wr_ptr_q] <= wr_beat;
  end

  always_ff @(posedge clk_125 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q   <= count_d;
      overflow  <= ovf_evt  | (overflow  & ~clr_status);
      frame_err <= ferr_evt | (frame_err & ~clr_status);
    end
  end

  assign rd_beat       = mem[rd_ptr_q];
  assign m_axis_tvalid = !empty;
  assign m_axis_tdata  = empty ? '0   : rd_beat.data;
  assign m_axis_tuser  = empty ? '0   : rd_beat.user;
  assign m_axis_tlast  = empty ? 1'b0 : rd_beat.last;
  assign fifo_level    = count_q;

`ifdef I2S_RX_ERRCNT_EN
  logic [15:0] err_cnt_q;
  logic [16:0] err_sum;

  // Clear and new events in one cycle: the events still count.
  always_comb begin
    err_sum = (clr_status ? 17'd0 : {1'b0, err_cnt_q}) + 17'(ovf_evt) + 17'(ferr_evt);
  end

  always_ff @(posedge clk_125 or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= '0;
    else        err_cnt_q <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  assign err_count = err_cnt_q;
`endif

endmodule
